// File: rtl/song_pkg.sv
// Shared definitions for the music-player note datapath: widths, the
// sequencer state encoding, the end-of-song marker and small helpers.
// Used by song_reader, the player control FSM and the note player.
package song_pkg;

    localparam int SONG_BITS  = 2;
    localparam int NOTE_BITS  = 5;
    localparam int NOTE_W     = 6;
    localparam int DUR_W      = 6;
    localparam int GAP_CYCLES = 4;
    localparam int ADDR_W     = SONG_BITS + NOTE_BITS;

    // A duration of zero in the song ROM marks the end of the song.
    localparam logic [DUR_W-1:0] END_DUR = {DUR_W{1'b0}};

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        WAIT_ROM = 3'd2,
        ISSUE    = 3'd3,
        PLAYING  = 3'd4,
        GAP      = 3'd5,
        DONE     = 3'd6,
        HALT     = 3'd7
    } song_state_t;

    function automatic logic is_end_marker(input logic [DUR_W-1:0] dur);
        return (dur == END_DUR);
    endfunction

    // The all-ones slot is the last one of a song; the index never wraps from it.
    function automatic logic is_last_note(input logic [NOTE_BITS-1:0] idx);
        return (idx == {NOTE_BITS{1'b1}});
    endfunction

endpackage

// File: rtl/song_reader_if.sv
// Bundle of the song_reader connections to the control FSM, the song ROM
// and the note player. The reader is the master: it drives the ROM address
// and the note/duration/status outputs.
interface song_reader_if;
    import song_pkg::*;

    logic                 play;
    logic                 reset_play;
    logic                 nextsong;
    logic                 note_done;
    logic [NOTE_W-1:0]    rom_note;
    logic [DUR_W-1:0]     rom_dur;
    logic [ADDR_W-1:0]    rom_addr;
    logic [NOTE_W-1:0]    note;
    logic [DUR_W-1:0]     duration;
    logic                 new_note;
    logic                 song_done;
    logic [SONG_BITS-1:0] song;

    modport master (
        input  play, reset_play, nextsong, note_done, rom_note, rom_dur,
        output rom_addr, note, duration, new_note, song_done, song
    );

    modport slave (
        output play, reset_play, nextsong, note_done, rom_note, rom_dur,
        input  rom_addr, note, duration, new_note, song_done, song
    );

endinterface

// File: rtl/song_gap_timer.sv
// Down-counter timing the silent gap between notes. load sets the count,
// en decrements it (stopping at zero), clear forces it to zero and wins
// over load. zero flags an expired count.
module song_gap_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt_r;

    // Gap counter: clear beats load beats decrement; holds at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {W{1'b0}};
        end else if (clear) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != {W{1'b0}})) begin
            cnt_r <= cnt_r - W'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/song_reader.sv
// Note sequencer for the music player. Walks the notes of the current song
// in a synchronous (1-cycle latency) song ROM and hands each note/duration
// pair to the note player with a new_note pulse, under play / reset_play /
// nextsong control. A zero duration or the last slot ends the song with a
// single song_done pulse, after which the reader halts until restarted.
// Optional feature macro: NOTE_GAP_EN inserts GAP_CYCLES silent cycles
// between notes (gap counter frozen while play is low).
module song_reader
    import song_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    song_reader_if.master bus
);

    song_state_t          state_r;
    song_state_t          state_s;
    logic [SONG_BITS-1:0] song_r;
    logic [NOTE_BITS-1:0] note_idx_r;
    logic [NOTE_W-1:0]    note_r;
    logic [DUR_W-1:0]     dur_r;
    logic                 new_note_r;
    logic                 song_done_r;
    logic                 wait_held_r;
    logic                 restart_s;
    logic                 advance_s;
    logic                 latch_s;
`ifdef NOTE_GAP_EN
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    logic                 gap_load_s;
    logic                 gap_en_s;
    logic                 gap_zero_s;
`endif

    // nextsong implies a restart; together with reset_play it is still one restart.
    assign restart_s = bus.reset_play | bus.nextsong;

    // Next-state logic; also decides when to advance the index and latch ROM data.
    always_comb begin
        state_s   = state_r;
        advance_s = 1'b0;
        latch_s   = 1'b0;
`ifdef NOTE_GAP_EN
        gap_load_s = 1'b0;
        gap_en_s   = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (bus.play) state_s = FETCH;
                else          state_s = IDLE;
            end
            FETCH: begin
                if (bus.play) state_s = WAIT_ROM;
                else          state_s = FETCH;
            end
            WAIT_ROM: begin
                // After a pause the read is taken one cycle later so the latched
                // data always comes from a read made while playing.
                if (bus.play && !wait_held_r) begin
                    if (is_end_marker(bus.rom_dur)) begin
                        state_s = DONE;
                    end else begin
                        state_s = ISSUE;
                        latch_s = 1'b1;
                    end
                end else begin
                    state_s = WAIT_ROM;
                end
            end
            ISSUE: begin
                if (bus.play) state_s = PLAYING;
                else          state_s = ISSUE;
            end
            PLAYING: begin
                // note_done is accepted even when paused: the player is finished.
                if (bus.note_done) begin
                    if (is_last_note(note_idx_r)) begin
                        state_s = DONE;
                    end else begin
                        advance_s = 1'b1;
`ifdef NOTE_GAP_EN
                        state_s    = GAP;
                        gap_load_s = 1'b1;
`else
                        state_s    = FETCH;
`endif
                    end
                end else begin
                    state_s = PLAYING;
                end
            end
            GAP: begin
`ifdef NOTE_GAP_EN
                gap_en_s = bus.play;
                if (bus.play && gap_zero_s) state_s = FETCH;
                else                        state_s = GAP;
`else
                state_s = IDLE;
`endif
            end
            DONE:    state_s = HALT;
            HALT:    state_s = HALT;
            default: state_s = IDLE;
        endcase
    end

    // Control state, song select and note index; restart overrides the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            song_r      <= {SONG_BITS{1'b0}};
            note_idx_r  <= {NOTE_BITS{1'b0}};
            new_note_r  <= 1'b0;
            song_done_r <= 1'b0;
            wait_held_r <= 1'b0;
        end else if (restart_s) begin
            state_r     <= IDLE;
            song_r      <= bus.nextsong ? (song_r + SONG_BITS'(1'b1)) : song_r;
            note_idx_r  <= {NOTE_BITS{1'b0}};
            new_note_r  <= 1'b0;
            song_done_r <= 1'b0;
            wait_held_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            song_r      <= song_r;
            note_idx_r  <= advance_s ? (note_idx_r + NOTE_BITS'(1'b1)) : note_idx_r;
            new_note_r  <= latch_s;
            song_done_r <= (state_s == DONE);
            wait_held_r <= (state_r == WAIT_ROM) && !bus.play;
        end
    end

    // Note/duration holding registers: load on issue, clear on reset/restart.
    always_ff @(posedge clk) begin
        if (reset || restart_s) begin
            note_r <= {NOTE_W{1'b0}};
            dur_r  <= {DUR_W{1'b0}};
        end else if (latch_s) begin
            note_r <= bus.rom_note;
            dur_r  <= bus.rom_dur;
        end else begin
            note_r <= note_r;
            dur_r  <= dur_r;
        end
    end

`ifdef NOTE_GAP_EN
    song_gap_timer #(
        .W (GAP_W)
    ) u_gap_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (restart_s),
        .load     (gap_load_s),
        .load_val (GAP_W'(GAP_CYCLES - 1)),
        .en       (gap_en_s),
        .zero     (gap_zero_s)
    );
`endif

    assign bus.rom_addr  = {song_r, note_idx_r};
    assign bus.note      = note_r;
    assign bus.duration  = dur_r;
    assign bus.new_note  = new_note_r;
    assign bus.song_done = song_done_r;
    assign bus.song      = song_r;

endmodule

// File: tb/tb_song_reader.sv
// Directed self-checking bench for song_reader (default build, no note gap).
// Provides a synchronous song ROM model, drives inputs on the falling edge
// and samples outputs on the falling edge.
module tb_song_reader;
    import song_pkg::*;

    logic clk;
    logic reset;

    song_reader_if bus ();

    song_reader u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [NOTE_W-1:0] note_mem [0:127];
    logic [DUR_W-1:0]  dur_mem  [0:127];

    int pass_cnt  = 0;
    int total_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous song ROM: data valid one cycle after the address.
    always_ff @(posedge clk) begin
        bus.rom_note <= note_mem[bus.rom_addr];
        bus.rom_dur  <= dur_mem[bus.rom_addr];
    end

    // Song 0 holds 5,7,9 (dur 4) and ends at slot 3; other songs never end early.
    function automatic logic [NOTE_W-1:0] exp_note(input int s, input int i);
        if (s == 0 && i < 3) return NOTE_W'(5 + 2 * i);
        else                 return NOTE_W'((s * 16 + i) % 64);
    endfunction

    function automatic logic [DUR_W-1:0] exp_dur(input int s, input int i);
        if (s == 0) return (i == 3) ? DUR_W'(0) : DUR_W'(4);
        else        return DUR_W'((i % 7) + 1);
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Optionally pulse note_done, then count cycles until new_note (bound 20).
    task automatic wait_note(input logic pulse_done, output int n, output int sd);
        logic got;
        got = 1'b0;
        n   = 20;
        sd  = 0;
        if (pulse_done) bus.note_done = 1'b1;
        for (int k = 1; k <= 20 && !got; k++) begin
            tick();
            bus.note_done = 1'b0;
            if (bus.song_done) sd++;
            if (bus.new_note) begin
                got = 1'b1;
                n   = k;
            end
        end
    endtask

    // Optionally pulse note_done, then count new_note and song_done pulses.
    task automatic count_window(input int cycles, input logic pulse_done,
                                output int nn, output int sd);
        nn = 0;
        sd = 0;
        if (pulse_done) bus.note_done = 1'b1;
        for (int k = 0; k < cycles; k++) begin
            tick();
            bus.note_done = 1'b0;
            if (bus.new_note)  nn++;
            if (bus.song_done) sd++;
        end
    endtask

    initial begin
        int n;
        int sd;
        int nn;

        for (int a = 0; a < 128; a++) begin
            note_mem[a] = exp_note(a / 32, a % 32);
            dur_mem[a]  = exp_dur(a / 32, a % 32);
        end
        reset          = 1'b1;
        bus.play       = 1'b0;
        bus.reset_play = 1'b0;
        bus.nextsong   = 1'b0;
        bus.note_done  = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        check("rst_note",      32'(bus.note),      0);
        check("rst_duration",  32'(bus.duration),  0);
        check("rst_new_note",  32'(bus.new_note),  0);
        check("rst_song_done", 32'(bus.song_done), 0);
        check("rst_song",      32'(bus.song),      0);
        check("rst_rom_addr",  32'(bus.rom_addr),  0);
        tick();
        check("idle_no_play", 32'(bus.new_note), 0);

        // Song 0: first note three cycles after play rises
        bus.play = 1'b1;
        wait_note(1'b0, n, sd);
        check("first_latency", 32'(n), 3);
        check("note0",         32'(bus.note), 5);
        check("dur0",          32'(bus.duration), 4);
        tick();
        wait_note(1'b1, n, sd);
        check("n2n_latency1", 32'(n), 3);
        check("note1",        32'(bus.note), 7);
        tick();
        wait_note(1'b1, n, sd);
        check("n2n_latency2", 32'(n), 3);
        check("note2",        32'(bus.note), 9);
        tick();
        count_window(10, 1'b1, nn, sd);
        check("end_song_done_pulses", 32'(sd), 1);
        check("end_no_new_note",      32'(nn), 0);
        check("end_rom_addr",         32'(bus.rom_addr), 3);
        check("end_note_held",        32'(bus.note), 9);
        count_window(5, 1'b0, nn, sd);
        check("halt_no_new_note",  32'(nn), 0);
        check("halt_no_song_done", 32'(sd), 0);

        // reset_play restarts song 0 and clears note/duration
        bus.reset_play = 1'b1;
        tick();
        bus.reset_play = 1'b0;
        check("rp_note",     32'(bus.note), 0);
        check("rp_duration", 32'(bus.duration), 0);
        check("rp_rom_addr", 32'(bus.rom_addr), 0);
        check("rp_song",     32'(bus.song), 0);
        wait_note(1'b0, n, sd);
        check("rp_latency", 32'(n), 3);
        check("rp_note0",   32'(bus.note), 5);

        // Pause in WAIT_ROM on the second note
        tick();
        bus.note_done = 1'b1;
        tick();
        bus.note_done = 1'b0;
        tick();
        bus.play = 1'b0;
        count_window(10, 1'b0, nn, sd);
        check("pause_no_new_note", 32'(nn), 0);
        check("pause_rom_addr",    32'(bus.rom_addr), 1);
        bus.play = 1'b1;
        wait_note(1'b0, n, sd);
        check("resume_latency", 32'(n), 2);
        check("resume_note",    32'(bus.note), 7);

        // Step to song 3, then nextsong while playing wraps to song 0
        bus.nextsong = 1'b1;
        repeat (3) tick();
        bus.nextsong = 1'b0;
        check("song3", 32'(bus.song), 3);
        wait_note(1'b0, n, sd);
        check("s3_latency", 32'(n), 3);
        check("s3_note0",   32'(bus.note), 32'(exp_note(3, 0)));
        tick();
        bus.nextsong = 1'b1;
        tick();
        bus.nextsong = 1'b0;
        check("wrap_song",      32'(bus.song), 0);
        check("wrap_rom_addr",  32'(bus.rom_addr), 0);
        check("wrap_new_note",  32'(bus.new_note), 0);
        check("wrap_song_done", 32'(bus.song_done), 0);
        wait_note(1'b0, n, sd);
        check("wrap_latency",   32'(n), 3);
        check("wrap_no_done",   32'(sd), 0);
        check("wrap_note0",     32'(bus.note), 5);

        // nextsong + reset_play + note_done together with song 1
        bus.nextsong = 1'b1;
        tick();
        bus.nextsong = 1'b0;
        wait_note(1'b0, n, sd);
        check("s1_note0", 32'(bus.note), 32'(exp_note(1, 0)));
        tick();
        bus.nextsong   = 1'b1;
        bus.reset_play = 1'b1;
        bus.note_done  = 1'b1;
        tick();
        bus.nextsong   = 1'b0;
        bus.reset_play = 1'b0;
        bus.note_done  = 1'b0;
        check("combo_song",     32'(bus.song), 2);
        check("combo_rom_addr", 32'(bus.rom_addr), 64);
        check("combo_new_note", 32'(bus.new_note), 0);
        wait_note(1'b0, n, sd);
        check("combo_latency",  32'(n), 3);
        check("combo_note0",    32'(bus.note), 32'(exp_note(2, 0)));

        // Song 2 has no end marker: all 32 slots play, then song_done
        for (int i = 1; i < 32; i++) begin
            tick();
            wait_note(1'b1, n, sd);
            check($sformatf("s2_latency_%0d", i), 32'(n), 3);
            check($sformatf("s2_note_%0d", i),    32'(bus.note), 32'(exp_note(2, i)));
            check($sformatf("s2_dur_%0d", i),     32'(bus.duration), 32'(exp_dur(2, i)));
        end
        tick();
        count_window(10, 1'b1, nn, sd);
        check("s2_song_done_pulses", 32'(sd), 1);
        check("s2_no_extra_note",    32'(nn), 0);
        check("s2_rom_addr_last",    32'(bus.rom_addr), 95);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
